// File: rtl/kb_key_event_ctrl.sv
// kb_key_event_ctrl
// Turns the raw PS/2 byte stream into press/release events for eight
// game-control keys. Prefix bytes (E0 extended, F0 break) are tracked by a
// small parser FSM. Typematic repeats are filtered against a held-key bitmap.
// Accepted events are queued in a FIFO that the game logic drains with a
// valid/ready handshake.
module kb_key_event_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_code_ready,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [2:0] ev_key,
    output logic       ev_press,
    output logic [7:0] key_state,
    output logic       overflow,
    input  logic       clear_ovf
);

    localparam logic [7:0]     CODE_EXT = 8'hE0;
    localparam logic [7:0]     CODE_BRK = 8'hF0;
    localparam logic [7:0]     CODE_PAU = 8'hE1;
    localparam logic [PTR_W:0] DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W - 1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } parse_state_t;

    // Maps a scan code to {hit, key index}. Extended and plain code sets are
    // disjoint, so the extended flag selects which table is consulted.
    function automatic logic [3:0] key_lookup(input logic [7:0] code, input logic ext);
        logic [3:0] res;
        res = 4'b0000;
        if (ext) begin
            case (code)
                8'h75:   res = 4'b1000;
                8'h72:   res = 4'b1001;
                8'h6B:   res = 4'b1010;
                8'h74:   res = 4'b1011;
                default: res = 4'b0000;
            endcase
        end else begin
            case (code)
                8'h29:   res = 4'b1100;
                8'h5A:   res = 4'b1101;
                8'h76:   res = 4'b1110;
                8'h4D:   res = 4'b1111;
                default: res = 4'b0000;
            endcase
        end
        return res;
    endfunction

    parse_state_t     state_r;
    parse_state_t     state_nxt_s;
    logic             do_lookup_s;
    logic             lookup_ext_s;
    logic             lookup_make_s;
    logic [3:0]       lookup_s;
    logic             hit_s;
    logic [2:0]       idx_s;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             wr_en_s;
    logic             drop_s;
    logic [7:0]       key_state_r;
    logic [7:0]       key_state_nxt_s;
    logic             overflow_r;
    logic [3:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   count_nxt_s;

    // Parser next-state: decides which prefix state follows each byte and
    // whether the byte should be looked up as a make or a break.
    always_comb begin
        state_nxt_s   = state_r;
        do_lookup_s   = 1'b0;
        lookup_ext_s  = 1'b0;
        lookup_make_s = 1'b0;
        if (scan_code_ready) begin
            if (scan_code == CODE_PAU) begin
                state_nxt_s = ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (scan_code == CODE_EXT) begin
                            state_nxt_s = ST_EXT;
                        end else if (scan_code == CODE_BRK) begin
                            state_nxt_s = ST_BRK;
                        end else begin
                            state_nxt_s   = ST_IDLE;
                            do_lookup_s   = 1'b1;
                            lookup_make_s = 1'b1;
                        end
                    end
                    ST_EXT: begin
                        if (scan_code == CODE_BRK) begin
                            state_nxt_s = ST_EXT_BRK;
                        end else if (scan_code == CODE_EXT) begin
                            state_nxt_s = ST_EXT;
                        end else begin
                            state_nxt_s   = ST_IDLE;
                            do_lookup_s   = 1'b1;
                            lookup_ext_s  = 1'b1;
                            lookup_make_s = 1'b1;
                        end
                    end
                    ST_BRK: begin
                        state_nxt_s = ST_IDLE;
                        do_lookup_s = 1'b1;
                    end
                    ST_EXT_BRK: begin
                        state_nxt_s  = ST_IDLE;
                        do_lookup_s  = 1'b1;
                        lookup_ext_s = 1'b1;
                    end
                    default: begin
                        state_nxt_s = ST_IDLE;
                    end
                endcase
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    assign lookup_s = key_lookup(scan_code, lookup_ext_s);
    assign hit_s    = do_lookup_s & lookup_s[3];
    assign idx_s    = lookup_s[2:0];

    // Event filter: a make only counts when the key was up, a break only when
    // it was down, which drops typematic repeats and stray breaks.
    always_comb begin
        key_state_nxt_s = key_state_r;
        push_s          = 1'b0;
        if (hit_s && (lookup_make_s != key_state_r[idx_s])) begin
            push_s                 = 1'b1;
            key_state_nxt_s[idx_s] = lookup_make_s;
        end else begin
            push_s = 1'b0;
        end
    end

    assign full_s  = (count_r == DEPTH_C);
    assign pop_s   = (count_r != {(PTR_W + 1){1'b0}}) & ev_ready;
    assign wr_en_s = push_s & (~full_s | pop_s);
    assign drop_s  = push_s & full_s & ~pop_s;

    // Occupancy bookkeeping for simultaneous push and pop.
    always_comb begin
        count_nxt_s = count_r;
        if (wr_en_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (pop_s && !wr_en_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Parser state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Held-key bitmap; reset forgets held keys without emitting releases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_state_r <= 8'h00;
        end else begin
            key_state_r <= key_state_nxt_s;
        end
    end

    // Event FIFO storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 4'b0000;
            end
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= {idx_s, lookup_make_s};
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clear_ovf) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign ev_valid  = (count_r != {(PTR_W + 1){1'b0}});
    assign ev_key    = ev_valid ? mem_r[rd_ptr_r][3:1] : 3'd0;
    assign ev_press  = ev_valid ? mem_r[rd_ptr_r][0]   : 1'b0;
    assign key_state = key_state_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_kb_key_event_ctrl.sv
// Bench for kb_key_event_ctrl: directed scenarios with literal expectations,
// then randomized byte traffic checked every cycle against a queue-based model.
module tb_kb_key_event_ctrl;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic [7:0] scan_code;
    logic       scan_code_ready;
    logic       ev_valid;
    logic       ev_ready;
    logic [2:0] ev_key;
    logic       ev_press;
    logic [7:0] key_state;
    logic       overflow;
    logic       clear_ovf;

    int checks = 0;
    int errors = 0;

    kb_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .reset(reset), .scan_code(scan_code),
        .scan_code_ready(scan_code_ready), .ev_valid(ev_valid),
        .ev_ready(ev_ready), .ev_key(ev_key), .ev_press(ev_press),
        .key_state(key_state), .overflow(overflow), .clear_ovf(clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: key table as {extended, code}, event queue, held keys, prefix flags.
    logic [8:0] ktab [8] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h029, 9'h05A, 9'h076, 9'h04D};
    logic [3:0] mq [$];
    bit   [7:0] mks = 8'h00;
    bit         movf = 1'b0;
    bit         mext = 1'b0;
    bit         mbrk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int find_key(input logic [7:0] code, input bit ext);
        for (int i = 0; i < 8; i++) begin
            if (ktab[i] == {ext, code}) return i;
        end
        return -1;
    endfunction

    // Reference model: advanced at every clock edge, cleared on reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            mks = 8'h00; movf = 1'b0; mext = 1'b0; mbrk = 1'b0;
        end else begin
            bit do_pop;
            bit do_push;
            logic [3:0] ev;
            int k;
            do_pop  = (mq.size() != 0) && ev_ready;
            do_push = 1'b0;
            ev      = 4'h0;
            if (scan_code_ready) begin
                if (scan_code == 8'hE1) begin
                    mext = 1'b0; mbrk = 1'b0;
                end else if (!mbrk && scan_code == 8'hE0) begin
                    mext = 1'b1;
                end else if (!mbrk && scan_code == 8'hF0) begin
                    mbrk = 1'b1;
                end else begin
                    k = find_key(scan_code, mext);
                    if (k >= 0) begin
                        if (!mbrk && !mks[k]) begin
                            mks[k] = 1'b1; do_push = 1'b1; ev = {k[2:0], 1'b1};
                        end else if (mbrk && mks[k]) begin
                            mks[k] = 1'b0; do_push = 1'b1; ev = {k[2:0], 1'b0};
                        end
                    end
                    mext = 1'b0; mbrk = 1'b0;
                end
            end
            if (do_pop) void'(mq.pop_front());
            if (do_push && mq.size() == DEPTH) movf = 1'b1;
            else begin
                if (do_push) mq.push_back(ev);
                if (clear_ovf) movf = 1'b0;
            end
        end
    end

    // Per-cycle compare of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        chk("ev_valid", ev_valid, (mq.size() != 0));
        chk("ev_key", ev_key, (mq.size() != 0) ? mq[0][3:1] : 3'd0);
        chk("ev_press", ev_press, (mq.size() != 0) ? mq[0][0] : 1'b0);
        chk("key_state", key_state, mks);
        chk("overflow", overflow, movf);
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        scan_code = b; scan_code_ready = 1'b1;
        @(posedge clk); #1;
        scan_code_ready = 1'b0; scan_code = 8'h00;
    endtask

    task automatic pop_chk(input string name, input logic [2:0] key, input logic press);
        chk({name, "_valid"}, ev_valid, 1'b1);
        chk({name, "_key"}, ev_key, key);
        chk({name, "_press"}, ev_press, press);
        ev_ready = 1'b1;
        @(posedge clk); #1;
        ev_ready = 1'b0;
    endtask

    logic [7:0] pool [14] = '{8'hE0, 8'hF0, 8'hE1, 8'h75, 8'h72, 8'h6B, 8'h74,
                              8'h29, 8'h5A, 8'h76, 8'h4D, 8'h1C, 8'hE0, 8'hF0};

    initial begin
        reset = 1'b0; scan_code = 8'h00; scan_code_ready = 1'b0;
        ev_ready = 1'b0; clear_ovf = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_valid", ev_valid, 1'b0);
        chk("rst_ks", key_state, 8'h00);
        chk("rst_ovf", overflow, 1'b0);
        reset = 1'b1;

        // Space make then break.
        send(8'h29);
        chk("sp_mk_valid", ev_valid, 1'b1);
        chk("sp_mk_ks", key_state, 8'h10);
        pop_chk("sp_mk", 3'd4, 1'b1);
        chk("sp_empty", ev_valid, 1'b0);
        send(8'hF0); send(8'h29);
        chk("sp_br_ks", key_state, 8'h00);
        pop_chk("sp_br", 3'd4, 1'b0);

        // Extended keys and typematic repeat.
        send(8'hE0); send(8'h75); send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        pop_chk("up_mk", 3'd0, 1'b1);
        pop_chk("up_br", 3'd0, 1'b0);
        chk("up_empty", ev_valid, 1'b0);
        send(8'h75);
        chk("plain75_valid", ev_valid, 1'b0);

        // Unmapped, false break and Pause sequence.
        send(8'h1C); send(8'hF0); send(8'h29);
        send(8'hE1); send(8'h14); send(8'h77);
        chk("unm_valid", ev_valid, 1'b0);
        chk("unm_ks", key_state, 8'h00);
        send(8'h5A);
        pop_chk("ent_mk", 3'd5, 1'b1);
        send(8'hF0); send(8'h5A);
        pop_chk("ent_br", 3'd5, 1'b0);

        // Overflow with consumer stalled.
        send(8'h29); send(8'h5A); send(8'h76); send(8'h4D);
        send(8'hE0); send(8'h6B);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_ks", key_state, 8'hF4);
        pop_chk("ovf0", 3'd4, 1'b1);
        pop_chk("ovf1", 3'd5, 1'b1);
        pop_chk("ovf2", 3'd6, 1'b1);
        pop_chk("ovf3", 3'd7, 1'b1);
        chk("ovf_empty", ev_valid, 1'b0);
        clear_ovf = 1'b1; @(posedge clk); #1; clear_ovf = 1'b0;
        chk("ovf_clr", overflow, 1'b0);

        // Full FIFO with push and pop in the same cycle.
        send(8'hF0); send(8'h29); send(8'hF0); send(8'h5A);
        send(8'hF0); send(8'h76); send(8'hF0); send(8'h4D);
        send(8'hE0);
        @(posedge clk); #1;
        scan_code = 8'h75; scan_code_ready = 1'b1; ev_ready = 1'b1;
        @(posedge clk); #1;
        scan_code_ready = 1'b0; ev_ready = 1'b0; scan_code = 8'h00;
        chk("pp_ovf", overflow, 1'b0);
        chk("pp_ks", key_state, 8'h05);
        pop_chk("pp0", 3'd5, 1'b0);
        pop_chk("pp1", 3'd6, 1'b0);
        pop_chk("pp2", 3'd7, 1'b0);
        pop_chk("pp3", 3'd0, 1'b1);
        chk("pp_empty", ev_valid, 1'b0);

        // Reset in the middle of an extended-break prefix.
        send(8'h29);
        send(8'hE0); send(8'hF0);
        #2 reset = 1'b0;
        #1;
        chk("mr_valid", ev_valid, 1'b0);
        chk("mr_key", ev_key, 3'd0);
        chk("mr_press", ev_press, 1'b0);
        chk("mr_ks", key_state, 8'h00);
        chk("mr_ovf", overflow, 1'b0);
        @(posedge clk); #3 reset = 1'b1;
        send(8'h75);
        chk("mr_75_valid", ev_valid, 1'b0);
        chk("mr_75_ks", key_state, 8'h00);

        // Randomized traffic checked by the per-cycle compare.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            scan_code_ready = ($urandom_range(0, 2) != 0);
            scan_code = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                    : pool[$urandom_range(0, 13)];
            ev_ready  = ($urandom_range(0, 2) == 0);
            clear_ovf = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                #3 reset = 1'b1;
            end
        end
        @(posedge clk); #1;
        scan_code_ready = 1'b0; ev_ready = 1'b0; clear_ovf = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
